// File: rtl/square_accum_pkg.sv
// Shared types and helpers for the square accumulator readout path.
// The enum holds the readout FSM states; the helper applies the offset correction.
package square_accum_pkg;

  localparam int ACCUM_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    CAPTURE
  } state_e;

  // Doubles the raw sum and adds one offset per sample. Callers truncate the result.
  function automatic logic [63:0] offset_correct(input logic [ACCUM_W-1:0] accum,
                                                 input logic [63:0] count,
                                                 input logic [63:0] offset);
    return {39'd0, accum, 1'b0} + count * offset;
  endfunction

endpackage

// File: rtl/square_5bit_accumulator.sv
// Squares a signed 5-bit sample and accumulates it when ce_i is high.
// A new sample shows up in accum_o two cycles after its ce_i cycle.
module square_5bit_accumulator
  import square_accum_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ce_i,
  input  logic signed [4:0]         x_i,
  output logic        [ACCUM_W-1:0] accum_o
);

  logic [4:0]         mag;
  logic [9:0]         sq_p0;
  logic               vld_p0;
  logic [ACCUM_W-1:0] accum_q;

  // -16 maps to 5'b10000, which reads back as 16.
  assign mag = x_i[4] ? $unsigned(-x_i) : $unsigned(x_i);

  // Stage p0: squared magnitude
  always_ff @(posedge clk_i) begin
    sq_p0 <= 10'(mag) * 10'(mag);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      accum_q <= '0;
    end else begin
      vld_p0 <= ce_i;
      // Stage p1: running sum
      if (vld_p0) begin
        accum_q <= accum_q + ACCUM_W'(sq_p0);
      end
    end
  end

  assign accum_o = accum_q;

endmodule

// File: rtl/square_power_monitor.sv
// Top-level pairing of the readout controller with the square accumulator.
// The sample is delayed one cycle so it lines up with the registered clock-enable.
module square_power_monitor
  import square_accum_pkg::*;
#(
  parameter int ACC_LATENCY = 2,
  parameter int OFFSET      = 1,
  parameter int CNT_W       = 16,
  parameter int OUT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  window_len_i,
  input  logic signed [4:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              ready_i,
  output logic [OUT_W-1:0]  power_o,
  output logic [CNT_W-1:0]  nsamp_o,
  output logic              valid_o,
  output logic              missed_o
);

  logic signed [4:0]  sample_q;
  logic               acc_ce;
  logic               acc_rst;
  logic [ACCUM_W-1:0] accum;

  always_ff @(posedge clk_i) begin
    sample_q <= sample_i;
  end

  square_5bit_accumulator u_acc (
    .clk_i   (clk_i),
    .rst_i   (acc_rst),
    .ce_i    (acc_ce),
    .x_i     (sample_q),
    .accum_o (accum)
  );

  square_accum_readout #(
    .ACC_LATENCY (ACC_LATENCY),
    .OFFSET      (OFFSET),
    .CNT_W       (CNT_W),
    .OUT_W       (OUT_W)
  ) u_readout (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .window_len_i   (window_len_i),
    .sample_valid_i (sample_valid_i),
    .acc_ce_o       (acc_ce),
    .acc_rst_o      (acc_rst),
    .accum_i        (accum),
    .power_o        (power_o),
    .nsamp_o        (nsamp_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .missed_o       (missed_o)
  );

endmodule

// File: rtl/square_accum_readout.sv
// Windowed readout of the square accumulator: gates ce over N valid samples, waits for
// the pipeline to settle, then publishes the corrected sum through a one-entry register.
module square_accum_readout
  import square_accum_pkg::*;
#(
  parameter int ACC_LATENCY = 2,
  parameter int OFFSET      = 1,
  parameter int CNT_W       = 16,
  parameter int OUT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [CNT_W-1:0]   window_len_i,
  input  logic               sample_valid_i,
  output logic               acc_ce_o,
  output logic               acc_rst_o,
  input  logic [ACCUM_W-1:0] accum_i,
  output logic [OUT_W-1:0]   power_o,
  output logic [CNT_W-1:0]   nsamp_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               missed_o
);

  localparam int                 DRAIN_W    = 8;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ACC_LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               acc_ce_q, acc_ce_d;
  logic               acc_rst_q, acc_rst_d;
  logic [OUT_W-1:0]   power_q, power_d;
  logic [CNT_W-1:0]   nsamp_q, nsamp_d;
  logic               valid_q, valid_d;
  logic               missed_q, missed_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      drain_q   <= '0;
      acc_ce_q  <= 1'b0;
      acc_rst_q <= 1'b1;
      power_q   <= '0;
      nsamp_q   <= '0;
      valid_q   <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      acc_ce_q  <= acc_ce_d;
      acc_rst_q <= acc_rst_d;
      power_q   <= power_d;
      nsamp_q   <= nsamp_d;
      valid_q   <= valid_d;
      missed_q  <= missed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = CLEAR;
      end
      CLEAR: begin
        // A zero length would never terminate the window, so it runs as one sample.
        len_d   = (window_len_i == '0) ? CNT_W'(1) : window_len_i;
        count_d = '0;
        drain_d = '0;
        state_d = RUN;
      end
      RUN: begin
        if (sample_valid_i) begin
          count_d = count_q + CNT_W'(1);
          if (count_q + CNT_W'(1) == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = en_i ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_ce_d  = (state_q == RUN) && sample_valid_i;
    acc_rst_d = (state_q == CLEAR);
    power_d   = power_q;
    nsamp_d   = nsamp_q;
    valid_d   = valid_q;
    missed_d  = 1'b0;
    if (state_q == CAPTURE) begin
      // An unaccepted result is never overwritten; the new one is dropped instead.
      if (!valid_q || ready_i) begin
        power_d = OUT_W'(offset_correct(accum_i, 64'(count_q), 64'(OFFSET)));
        nsamp_d = count_q;
        valid_d = 1'b1;
      end else begin
        missed_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign acc_ce_o  = acc_ce_q;
  assign acc_rst_o = acc_rst_q;
  assign power_o   = power_q;
  assign nsamp_o   = nsamp_q;
  assign valid_o   = valid_q;
  assign missed_o  = missed_q;

endmodule

// File: tb/tb_square_accum_readout.sv
// Bench for square_accum_readout: a behavioural accumulator feeds accum_i, a directed
// table plus corner sequences cover the handshake, and a random run uses a window-level model.
module tb_square_accum_readout;

  localparam int LAT = 2;
  localparam int OFF = 1;
  localparam int CW  = 16;
  localparam int OW  = 32;
  localparam int RT  = 1500;

  logic          clk = 1'b0;
  logic          rst, en, sv, ready;
  logic [CW-1:0] wl;
  logic          acc_ce, acc_rst, valid, missed;
  logic [23:0]   accum;
  logic [OW-1:0] power;
  logic [CW-1:0] nsamp;

  always #5 clk = ~clk;

  square_accum_readout #(
    .ACC_LATENCY (LAT),
    .OFFSET      (OFF),
    .CNT_W       (CW),
    .OUT_W       (OW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .window_len_i   (wl),
    .sample_valid_i (sv),
    .acc_ce_o       (acc_ce),
    .acc_rst_o      (acc_rst),
    .accum_i        (accum),
    .power_o        (power),
    .nsamp_o        (nsamp),
    .valid_o        (valid),
    .ready_i        (ready),
    .missed_o       (missed)
  );

  function automatic int sqv(input logic signed [4:0] x);
    int v;
    v = x;
    return v * v;
  endfunction

  // Accumulator stand-in: sample delayed one cycle, result settles two cycles after ce.
  logic signed [4:0] sample     = '0;
  logic signed [4:0] sample_dly = '0;
  logic [9:0]        pm         = '0;
  logic              pv         = 1'b0;
  logic [23:0]       acc_m      = '0;
  always @(posedge clk) begin
    sample_dly <= sample;
    if (acc_rst) begin
      pv    <= 1'b0;
      pm    <= '0;
      acc_m <= '0;
    end else begin
      pv <= acc_ce;
      pm <= 10'(sqv(sample_dly));
      if (pv) acc_m <= acc_m + 24'(pm);
    end
  end
  assign accum = acc_m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sv = 1'b0; ready = 1'b0; wl = '0; sample = '0;
    tick();
    tick();
    chk("rst_ce", acc_ce, 0);
    chk("rst_accrst", acc_rst, 1);
    chk("rst_valid", valid, 0);
    chk("rst_missed", missed, 0);
    chk("rst_power", power, 0);
    chk("rst_nsamp", nsamp, 0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    int          len;
    int          n;
    logic [7:0]  mask;
    logic [24:0] d;
    longint      exp_p;
    int          exp_n;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [24:0] pk(input int a, input int b, input int c,
                                     input int d, input int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // Random-run stimulus and window-level expectations, indexed by cycle.
  bit          vv    [RT];
  logic [4:0]  dd    [RT];
  bit          rr    [RT];
  logic [15:0] wlr   [RT];
  bit          run_m [RT];
  bit          cap_m [RT];
  longint      rp    [RT];
  int          rn    [RT];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit     ok;
    longint p1;
    int     misses;
    int     c, t, cnt, L, capt;
    longint sum;
    bit     m_v, m_miss;
    longint m_p;
    int     m_n;

    tbl[0] = '{len: 4, n: 4, mask: 8'b0000_1111, d: pk(1, 2, 3, 0, 0),    exp_p: 32,   exp_n: 4};
    tbl[1] = '{len: 3, n: 5, mask: 8'b0001_0101, d: pk(1, 7, 2, 7, 3),    exp_p: 31,   exp_n: 3};
    tbl[2] = '{len: 0, n: 1, mask: 8'b0000_0001, d: pk(5, 0, 0, 0, 0),    exp_p: 51,   exp_n: 1};
    tbl[3] = '{len: 1, n: 1, mask: 8'b0000_0001, d: pk(-16, 0, 0, 0, 0),  exp_p: 513,  exp_n: 1};
    tbl[4] = '{len: 2, n: 2, mask: 8'b0000_0011, d: pk(-3, 15, 0, 0, 0),  exp_p: 470,  exp_n: 2};
    tbl[5] = '{len: 5, n: 5, mask: 8'b0001_1111, d: pk(15, 15, 15, 15, 15), exp_p: 2255, exp_n: 5};

    // Single windows with en_i dropped during RUN, ready_i held high.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      en = 1'b1; wl = CW'(tbl[i].len); ready = 1'b1;
      tick();
      tick();
      en = 1'b0;
      for (int k = 0; k < tbl[i].n; k++) begin
        sv = tbl[i].mask[k];
        sample = tbl[i].d[k*5 +: 5];
        tick();
        chk($sformatf("tbl%0d_ce%0d", i, k), acc_ce, 64'(tbl[i].mask[k]));
      end
      sv = 1'b0; sample = '0;
      wait_valid(16, ok);
      chk($sformatf("tbl%0d_done", i), ok, 1);
      if (ok) begin
        chk($sformatf("tbl%0d_power", i), power, 64'(tbl[i].exp_p));
        chk($sformatf("tbl%0d_nsamp", i), nsamp, 64'(tbl[i].exp_n));
        sv = 1'b1;
        tick();
        chk($sformatf("tbl%0d_accepted", i), valid, 0);
        for (int k = 0; k < 4; k++) begin
          tick();
          chk($sformatf("tbl%0d_idle_ce", i), acc_ce, 0);
          chk($sformatf("tbl%0d_idle_valid", i), valid, 0);
          chk($sformatf("tbl%0d_idle_accrst", i), acc_rst, 0);
        end
      end
    end

    // Result held across a second window that gets dropped.
    do_reset();
    en = 1'b1; wl = 2; sv = 1'b1; sample = 3; ready = 1'b0;
    wait_valid(30, ok);
    chk("hold_first", ok, 1);
    en = 1'b0;
    p1 = 64'(power);
    chk("hold_power0", power, 38);
    chk("hold_nsamp0", nsamp, 2);
    sample = 1;
    misses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (missed === 1'b1) misses++;
      chk("hold_valid", valid, 1);
      chk("hold_power", power, 38);
    end
    chk("hold_missed_count", misses, 1);
    ready = 1'b1;
    tick();
    chk("hold_accepted", valid, 0);
    ready = 1'b0;

    // Accept coincides with CAPTURE: new result replaces the old one without a miss.
    do_reset();
    en = 1'b1; wl = 1; sv = 1'b1; sample = 3; ready = 1'b0;
    wait_valid(30, ok);
    chk("coinc_first", ok, 1);
    chk("coinc_power0", power, 19);
    sample = 4;
    for (int k = 0; k < 4; k++) tick();
    ready = 1'b1;
    tick();
    en = 1'b0;
    chk("coinc_valid", valid, 1);
    chk("coinc_power", power, 33);
    chk("coinc_nsamp", nsamp, 1);
    chk("coinc_missed", missed, 0);

    // Reset in the middle of a window, then a fresh window.
    do_reset();
    en = 1'b1; wl = 8; sv = 1'b1; sample = 5; ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_accrst", acc_rst, 1);
    chk("midrst_valid", valid, 0);
    chk("midrst_ce", acc_ce, 0);
    chk("midrst_missed", missed, 0);
    rst = 1'b0; en = 1'b1; wl = 2; sample = 2;
    wait_valid(30, ok);
    chk("midrst_done", ok, 1);
    chk("midrst_power", power, 18);
    chk("midrst_nsamp", nsamp, 2);
    en = 1'b0;

    // Random run: window boundaries and results derived from the stimulus arrays.
    for (int i = 0; i < RT; i++) begin
      vv[i]    = ($urandom_range(0, 9) < 7);
      dd[i]    = 5'($urandom);
      rr[i]    = 1'($urandom_range(0, 1));
      wlr[i]   = 16'($urandom_range(0, 5));
      run_m[i] = 1'b0;
      cap_m[i] = 1'b0;
      rp[i]    = 0;
      rn[i]    = 0;
    end
    c = 1;
    while (c < RT) begin
      L = (wlr[c] == 0) ? 1 : int'(wlr[c]);
      cnt = 0; sum = 0; t = c + 1;
      while (t < RT && cnt < L) begin
        run_m[t] = 1'b1;
        if (vv[t]) begin
          cnt++;
          sum += sqv(dd[t]);
        end
        t++;
      end
      if (cnt < L) break;
      capt = t - 1 + LAT + 1;
      if (capt >= RT) break;
      cap_m[capt] = 1'b1;
      rp[capt] = 2 * sum + L * OFF;
      rn[capt] = L;
      c = capt + 1;
    end

    do_reset();
    m_v = 1'b0; m_miss = 1'b0; m_p = 0; m_n = 0;
    for (int i = 0; i < RT; i++) begin
      chk("rnd_valid", valid, 64'(m_v));
      chk("rnd_missed", missed, 64'(m_miss));
      chk("rnd_ce", acc_ce, 64'((i > 0) && run_m[i-1] && vv[i-1]));
      if (m_v) begin
        chk("rnd_power", power, 64'(m_p));
        chk("rnd_nsamp", nsamp, 64'(m_n));
      end
      en = 1'b1; sv = vv[i]; sample = dd[i]; ready = rr[i]; wl = wlr[i];
      if (cap_m[i]) begin
        if (!m_v || rr[i]) begin
          m_p = rp[i]; m_n = rn[i]; m_v = 1'b1; m_miss = 1'b0;
        end else begin
          m_miss = 1'b1;
        end
      end else begin
        m_miss = 1'b0;
        if (m_v && rr[i]) m_v = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
